gt_drp_arbiter: RTL

GT_DRP_ARBITER -- requirements
Module: gt_drp_arbiter

---
 rtl/gt_drp_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gt_drp_arbiter.sv
// Two-requester arbiter for a single GT channel DRP port. Requests are
// buffered per requester, granted round-robin, and issued one at a time.
// Each DRP transaction is bounded by a WAIT-state timeout.

// Per-requester request buffer and pending flag.
module gt_drp_req_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [8:0]  addr,
  input  logic [15:0] di,
  input  logic        clr,
  output logic        pend,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [15:0] buf_di
);
  // Latch on accept. Strobes are dropped while pending, which also
  // covers the DONE cycle because clr only fires while pend is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_di   <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (en && !pend) begin
      pend     <= 1'b1;
      buf_we   <= we;
      buf_addr <= addr;
      buf_di   <= di;
    end
  end
endmodule

module gt_drp_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        i_drpclk_in,
  input  logic        i_drp_reset,
  input  logic        i_req0_en,
  input  logic        i_req1_en,
  input  logic        i_req0_we,
  input  logic        i_req1_we,
  input  logic [8:0]  i_req0_addr,
  input  logic [8:0]  i_req1_addr,
  input  logic [15:0] i_req0_di,
  input  logic [15:0] i_req1_di,
  output logic [15:0] o_req0_do,
  output logic [15:0] o_req1_do,
  output logic        o_req0_rdy,
  output logic        o_req1_rdy,
  output logic        o_req0_err,
  output logic        o_req1_err,
  output logic        o_req0_busy,
  output logic        o_req1_busy,
  output logic [8:0]  o_drpaddr,
  output logic [15:0] o_drpdi,
  output logic        o_drpen,
  output logic        o_drpwe,
  input  logic [15:0] i_drpdo,
  input  logic        i_drprdy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_t            state;
  logic              sel, last, pick;
  logic [15:0]       cnt;
  logic [1:0]        req_en, req_we, pend, clr, buf_we, rdy, err;
  logic [1:0][8:0]   req_addr, buf_addr;
  logic [1:0][15:0]  req_di, buf_di, rsp_do;

  assign req_en   = {i_req1_en, i_req0_en};
  assign req_we   = {i_req1_we, i_req0_we};
  assign req_addr = {i_req1_addr, i_req0_addr};
  assign req_di   = {i_req1_di, i_req0_di};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    gt_drp_req_lane u_lane (
      .clk      (i_drpclk_in),
      .rst      (i_drp_reset),
      .en       (req_en[g]),
      .we       (req_we[g]),
      .addr     (req_addr[g]),
      .di       (req_di[g]),
      .clr      (clr[g]),
      .pend     (pend[g]),
      .buf_we   (buf_we[g]),
      .buf_addr (buf_addr[g]),
      .buf_di   (buf_di[g])
    );
  end

  // On a tie the requester not granted last wins.
  assign pick = (&pend) ? ~last : pend[1];
  // Pending of the served requester drops at the edge that leaves DONE.
  assign clr  = (state == DONE) ? {sel, ~sel} : 2'b00;

  // Arbitration FSM driving the DRP port and the per-requester responses.
  always_ff @(posedge i_drpclk_in) begin
    if (i_drp_reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      o_drpen   <= 1'b0;
      o_drpwe   <= 1'b0;
      o_drpaddr <= '0;
      o_drpdi   <= '0;
      rdy       <= '0;
      err       <= '0;
      rsp_do    <= '0;
    end else begin
      o_drpen <= 1'b0;
      o_drpwe <= 1'b0;
      rdy     <= '0;
      err     <= '0;
      case (state)
        IDLE: if (|pend) begin
          sel       <= pick;
          o_drpen   <= 1'b1;
          o_drpwe   <= buf_we[pick];
          o_drpaddr <= buf_addr[pick];
          o_drpdi   <= buf_di[pick];
          state     <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A response on the final count still wins over the timeout.
          if (i_drprdy) begin
            rsp_do[sel] <= i_drpdo;
            rdy[sel]    <= 1'b1;
            state       <= DONE;
          end else if (cnt == CNT_MAX) begin
            rsp_do[sel] <= 16'hFFFF;
            rdy[sel]    <= 1'b1;
            err[sel]    <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req0_do   = rsp_do[0];
  assign o_req1_do   = rsp_do[1];
  assign o_req0_rdy  = rdy[0];
  assign o_req1_rdy  = rdy[1];
  assign o_req0_err  = err[0];
  assign o_req1_err  = err[1];
  assign o_req0_busy = pend[0];
  assign o_req1_busy = pend[1];
endmodule
